// File: rtl/hdmi_pixel_fetch_if.sv
// hdmi_pixel_fetch_if: DDR read port between the pixel fetcher
// and the frame-buffer memory; requests accepted and returned in order.
interface hdmi_pixel_fetch_if #(
  parameter int ADDR_W = 28
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_data_valid;
  logic [127:0]      rd_data;

  modport master (
    output rd_req, rd_addr,
    input  rd_ack, rd_data_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ack, rd_data_valid, rd_data
  );
endinterface

// File: rtl/hdmi_pixel_fetch.sv
// hdmi_pixel_fetch: DDR word fetch, word FIFO and 12-bit pixel unpacker.
// HDMI_FETCH_UFLOW_MARK_EN selects a magenta underflow fill pixel.
module hdmi_pixel_fetch #(
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 28,
  parameter int FRAME_WORDS = 38400,
  parameter int DEPTH       = 16,
  parameter int MAX_OUT     = 4
) (
  input  logic                   hdmi_clk_i,
  input  logic                   hdmi_rst_n,
  input  logic                   frame_start,
  hdmi_pixel_fetch_if.master     rd,
  input  logic                   pix_req,
  output logic [11:0]            pix_data,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int LW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);
`ifdef HDMI_FETCH_UFLOW_MARK_EN
  localparam logic [11:0] FILL = 12'hF0F;
`else
  localparam logic [11:0] FILL = 12'h000;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [WW-1:0]     issued;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     out_nx;
  logic [OW-1:0]     discard;
  logic              req, acc, ret;
  logic              can_req, last;
  logic              wr, pop;
  logic [LW-1:0]     wp, rp;
  logic [127:0]      mem [DEPTH];
  logic [127:0]      head, cur;
  logic [2:0]        idx;
  logic              have;

  assign rd.rd_req  = req;
  assign rd.rd_addr = addr;
  assign acc    = req & rd.rd_ack;
  assign ret    = rd.rd_data_valid;
  assign out_nx = outstanding + OW'(acc) - OW'(ret);
  assign last   = int'(issued) == FRAME_WORDS - 1;

  // Headroom counts words in flight, so the FIFO can never overflow.
  assign can_req = int'(issued) < FRAME_WORDS
    && int'(fifo_level) + int'(outstanding) < DEPTH
    && int'(outstanding) < MAX_OUT;

  assign wr   = ret & ~frame_start & (discard == '0);
  assign pop  = pix_req & ~frame_start & ~have
    & (fifo_level != '0);
  assign head = mem[rp];

  // Request state register.
  always_ff @(posedge hdmi_clk_i or negedge hdmi_rst_n)
    if (!hdmi_rst_n) state <= IDLE;
    else             state <= state_nx;

  // Next request state; rd_req is a pure decode of REQ.
  always_comb begin
    state_nx = state;
    req      = 1'b0;
    unique case (state)
      IDLE: if (can_req) state_nx = REQ;
      REQ: begin
        req = 1'b1;
        if (rd.rd_ack) state_nx = last ? DONE : IDLE;
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (frame_start) state_nx = IDLE;
  end

  // Address, issue and in-flight counters; restart arms the discard.
  always_ff @(posedge hdmi_clk_i or negedge hdmi_rst_n)
    if (!hdmi_rst_n) begin
      addr        <= ADDR_W'(BASE_ADDR);
      issued      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nx;
      if (frame_start) begin
        addr    <= ADDR_W'(BASE_ADDR);
        issued  <= '0;
        discard <= out_nx;
      end else begin
        if (acc) begin
          addr   <= addr + 1'b1;
          issued <= issued + 1'b1;
        end
        if (ret && discard != '0) discard <= discard - 1'b1;
      end
    end

  // Word storage, no reset needed.
  always_ff @(posedge hdmi_clk_i)
    if (wr) mem[wp] <= rd.rd_data;

  // FIFO pointers and registered occupancy.
  always_ff @(posedge hdmi_clk_i or negedge hdmi_rst_n)
    if (!hdmi_rst_n) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else if (frame_start) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level
        + (LW+1)'(wr) - (LW+1)'(pop);
    end

  // Unpacker: words are loaded on demand, pixel 0 first.
  always_ff @(posedge hdmi_clk_i or negedge hdmi_rst_n)
    if (!hdmi_rst_n) begin
      cur       <= '0;
      idx       <= '0;
      have      <= 1'b0;
      pix_data  <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      idx       <= '0;
      have      <= 1'b0;
      underflow <= 1'b0;
    end else if (pix_req) begin
      unique case (1'b1)
        have: begin
          pix_data <= cur[{idx, 4'd0} +: 12];
          idx      <= idx + 3'd1;
          if (idx == 3'd7) have <= 1'b0;
        end
        pop: begin
          pix_data <= head[11:0];
          cur      <= head;
          idx      <= 3'd1;
          have     <= 1'b1;
        end
        default: begin
          pix_data  <= FILL;
          underflow <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
// tb_hdmi_pixel_fetch: queue-based reference model of fetch, discard
// and unpack, driven by a random-latency in-order memory.
module tb_hdmi_pixel_fetch;
  localparam int BASE  = 64;
  localparam int AW    = 28;
  localparam int FW    = 48;
  localparam int DEPTH = 16;
  localparam int MAXO  = 4;
  localparam int LW    = $clog2(DEPTH);
`ifdef HDMI_FETCH_UFLOW_MARK_EN
  localparam logic [11:0] FILL = 12'hF0F;
`else
  localparam logic [11:0] FILL = 12'h000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          pix_req;
  logic [11:0]   pix_data;
  logic          underflow;
  logic [LW:0]   fifo_level;

  hdmi_pixel_fetch_if #(.ADDR_W(AW)) rd ();

  hdmi_pixel_fetch #(
    .BASE_ADDR(BASE), .ADDR_W(AW), .FRAME_WORDS(FW),
    .DEPTH(DEPTH), .MAX_OUT(MAXO)
  ) dut (
    .hdmi_clk_i(clk),
    .hdmi_rst_n(rst_n),
    .frame_start(frame_start),
    .rd(rd),
    .pix_req(pix_req),
    .pix_data(pix_data),
    .underflow(underflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_min = 5;
  int lat_max = 5;

  logic [11:0]  m_pix;
  bit           m_uf;
  int           m_addr, m_issued, m_disc, last_acc;
  logic [127:0] wordq[$];
  logic [11:0]  pixq[$];
  int           pend_addr[$];
  int           pend_due[$];

  function automatic logic [127:0] mkword(input int a);
    logic [127:0] w;
    for (int k = 0; k < 8; k++)
      w[16*k +: 16] = {4'(a) ^ 4'h5, 8'(a), 4'(k)};
    return w;
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    wordq.delete();
    pixq.delete();
    pend_addr.delete();
    pend_due.delete();
    m_pix = '0;
    m_uf = 1'b0;
    m_addr = BASE;
    m_issued = 0;
    m_disc = 0;
    last_acc = -1;
  endtask

  // One clock: compare, drive inputs, advance model and memory.
  task automatic step(input bit fs, input int pr_pct,
                      input int ack_pct);
    bit pr, ack, v, acc;
    logic [127:0] w, w2;
    int due;
    @(negedge clk);
    chk("pix_data", pix_data, m_pix);
    chk("underflow", underflow, m_uf);
    chk("fifo_level", fifo_level, wordq.size());
    if (rd.rd_req) begin
      chk("rd_addr", rd.rd_addr, m_addr);
      chk("issue_limit", m_issued < FW, 1);
    end
    pr  = $urandom_range(99) < pr_pct;
    ack = $urandom_range(99) < ack_pct;
    v   = pend_due.size() > 0 && pend_due[0] <= cyc;
    w   = v ? mkword(pend_addr[0])
            : {$urandom(), $urandom(), $urandom(), $urandom()};
    frame_start      = fs;
    pix_req          = pr;
    rd.rd_ack        = ack;
    rd.rd_data_valid = v;
    rd.rd_data       = w;
    acc = rd.rd_req && ack;
    if (v) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (acc) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (pend_due.size() > 0 && due <= pend_due[$])
        due = pend_due[$] + 1;
      pend_addr.push_back(m_addr);
      pend_due.push_back(due);
    end
    if (fs) begin
      wordq.delete();
      pixq.delete();
      m_uf = 1'b0;
      m_addr = BASE;
      m_issued = 0;
      m_disc = pend_addr.size();
      last_acc = -1;
    end else begin
      if (pr) begin
        if (pixq.size() == 0 && wordq.size() > 0) begin
          w2 = wordq.pop_front();
          for (int k = 0; k < 8; k++)
            pixq.push_back(w2[16*k +: 12]);
        end
        if (pixq.size() > 0) m_pix = pixq.pop_front();
        else begin
          m_pix = FILL;
          m_uf = 1'b1;
        end
      end
      if (acc) begin
        last_acc = m_addr;
        m_addr++;
        m_issued++;
      end
      if (v) begin
        if (m_disc > 0) m_disc--;
        else wordq.push_back(w);
      end
    end
    chk("max_outstanding", pend_addr.size() <= MAXO, 1);
    chk("headroom",
        wordq.size() + pend_addr.size() <= DEPTH, 1);
    cyc++;
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    frame_start = 1'b0;
    pix_req = 1'b0;
    rd.rd_ack = 1'b0;
    rd.rd_data_valid = 1'b0;
    rd.rd_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rd_req", rd.rd_req, 0);
    chk("rst_rd_addr", rd.rd_addr, BASE);
    chk("rst_pix", pix_data, 0);
    chk("rst_uflow", underflow, 0);
    chk("rst_level", fifo_level, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill with fixed latency 5 and rd_ack always high.
    step(1, 0, 100);
    repeat (100) step(0, 0, 100);
    chk("fill_level", fifo_level, 16);

    // Unpack order of word 64, then first pixel of word 65.
    step(0, 100, 100);
    for (int i = 1; i <= 9; i++) begin
      step(0, (i < 9) ? 100 : 0, 100);
      chk("unpack_order", pix_data,
          (i <= 8) ? 12'h400 + 12'(i - 1) : 12'h410);
    end

    // Underflow with no acks, then retry of pixel 0.
    step(1, 0, 0);
    repeat (3) step(0, 100, 0);
    chk("uflow_pix", pix_data, FILL);
    chk("uflow_flag", underflow, 1);
    repeat (4) step(0, 100, 0);
    step(1, 0, 100);
    step(0, 0, 100);
    chk("uflow_clear", underflow, 0);
    repeat (30) step(0, 0, 100);
    step(0, 100, 100);
    step(0, 0, 100);
    chk("retry_pix0", pix_data, 12'h400);

    // Restart with three reads in flight.
    step(1, 0, 100);
    n = 0;
    while (pend_addr.size() != 3 && n < 40) begin
      step(0, 0, 100);
      n++;
    end
    chk("pend3_reached", pend_addr.size(), 3);
    step(1, 0, 100);
    repeat (6) step(0, 0, 100);
    chk("restart_level", fifo_level, 0);

    // Frame end: exactly FW requests, then rd_req stays low.
    step(1, 100, 100);
    n = 0;
    while (m_issued < FW && n < 1000) begin
      step(0, 100, 100);
      n++;
    end
    repeat (40) step(0, 100, 100);
    chk("frame_words", m_issued, FW);
    chk("frame_last_addr", last_acc, BASE + FW - 1);

    // Random traffic with random in-order latency.
    lat_min = 1;
    lat_max = 8;
    step(1, 40, 60);
    repeat (3000)
      step($urandom_range(399) == 0, 40, 60);

    // Asynchronous reset between edges, mid-burst.
    lat_min = 3;
    lat_max = 3;
    step(1, 30, 100);
    repeat (12) step(0, 30, 100);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_rd_req", rd.rd_req, 0);
    chk("areset_rd_addr", rd.rd_addr, BASE);
    chk("areset_pix", pix_data, 0);
    chk("areset_uflow", underflow, 0);
    chk("areset_level", fifo_level, 0);
    frame_start = 1'b0;
    pix_req = 1'b0;
    rd.rd_ack = 1'b0;
    rd.rd_data_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 50, 80);
    repeat (300) step(0, 50, 80);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/hdmi_pixel_fetch.md
# hdmi_pixel_fetch

Upstream feeder for the HDMI display timing stage. Reads 128-bit frame-buffer words from the DDR read port, buffers them in a small word FIFO, and unpacks them into 12-bit pixels. The display stage pulls these pixels one per active-video cycle. It drives the display stage's `ddr_data` input. Timing alignment with the display stage's data-enable is handled by that stage's `number_delay` setting of 1.

## Interface
Parameters:
- `BASE_ADDR`, 0: word address of pixel (0,0).
- `ADDR_W`, 28: DDR word-address width.
- `FRAME_WORDS`, 38400: words per frame (640×480 / 8).
- `DEPTH`, 16: FIFO depth in 128-bit words; power of two.
- `MAX_OUT`, 4: maximum accepted-but-unreturned reads.

Ports:
- `hdmi_clk_i`  in  1: pixel clock. All logic is in this single domain.
- `hdmi_rst_n`  in  1: asynchronous, active-low reset.
- `frame_start`  in  1: one-cycle pulse that restarts the frame.
- `rd_req`  out  1: read request.
- `rd_addr`  out  ADDR_W: read word address.
- `rd_ack`  in  1: request accepted this cycle.
- `rd_data_valid`  in  1: a read word returns this cycle, in request order.
- `rd_data`  in  128: returned word.
- `pix_req`  in  1: consume one pixel.
- `pix_data`  out  12: current pixel.
- `underflow`  out  1: sticky flag, set when a pixel was needed and none was available.
- `fifo_level`  out  $clog2(DEPTH)+1: FIFO occupancy in words.

## Operation
- **Word format:** pixel k (k = 0..7) is `rd_data[16k+11:16k]`. Bits `[16k+15:16k+12]` are ignored. Pixel 0 is shown first.
- **Request FSM:**
  - States: IDLE, REQ, DONE.
  - IDLE→REQ when `words_issued < FRAME_WORDS` and `fifo_level + outstanding < DEPTH` and `outstanding < MAX_OUT`.
  - REQ holds `rd_req`=1 with `rd_addr` stable until `rd_ack`. On `rd_req & rd_ack`: `rd_addr += 1`, `words_issued += 1`, `outstanding += 1`, then go to IDLE, or to DONE when `words_issued` reaches FRAME_WORDS.
  - DONE stays until `frame_start`.
- **Returns:** on `rd_data_valid`, `outstanding -= 1`. The word is written to the FIFO unless `discard_cnt > 0`; in that case it is dropped and `discard_cnt -= 1`. Headroom checking makes FIFO overflow impossible.
- **Unpacker:** holds the current word and a 3-bit index.
  - On `pix_req`, `pix_data` is registered from the pixel at the current index, and the index increments.
  - When a `pix_req` consumes index 7, the next FIFO word is loaded and the index wraps to 0.
  - If a word is needed and the FIFO is empty, `pix_data` becomes the fill value, `underflow` is set, and the index does not advance. The same pixel is retried on the next `pix_req`.
  - With no `pix_req`, `pix_data` holds its value.
- **frame_start:**
  - FIFO is flushed, the unpacker is emptied, `rd_addr` returns to BASE_ADDR, `words_issued` to 0, and `underflow` is cleared.
  - `discard_cnt` takes the current `outstanding` (plus 1 if `rd_ack` fires in the same cycle). The FSM goes to IDLE.
  - A request pending in REQ without `rd_ack` is withdrawn.
  - `frame_start` has priority over a simultaneous `pix_req`, `rd_data_valid`, or `rd_ack`. Those events are dropped, or counted for discard, as described above.
- **Reset values:** `rd_req` 0, `rd_addr` BASE_ADDR, `pix_data` 0, `underflow` 0, `fifo_level` 0, FSM IDLE, all counters 0.

## Timing
- `pix_data` updates on the clock edge after the `pix_req` cycle, a fixed latency of 1.
- FIFO write→read: a word written in cycle n can be loaded by the unpacker in cycle n+1. There is no same-cycle bypass.
- `fifo_level` is registered. It updates the cycle after a write or read; a simultaneous write and read leaves it unchanged.
- `rd_req` asserts at the earliest 1 cycle after the IDLE condition holds. Back-to-back accepted requests occur at most every 2 cycles.
- `underflow` is set on the same edge as the fill pixel. It clears only on `frame_start` or reset.

## Configuration
- `HDMI_FETCH_UFLOW_MARK_EN`:
  - Defined: the underflow fill value is 12'hF0F (magenta marker).
  - Undefined: the fill value is 12'h000.
  - All other behaviour is identical either way.

## Test plan
- **Reset and fill:** reset, then `frame_start`, with `rd_ack` always 1 and read latency 5 cycles. Expect `rd_addr` 0,1,2,… and `fifo_level` settling at 16. Expect at most 4 outstanding reads at any time.
- **Unpack order:** FIFO word = 128'h…0007_0006_0005_0004_0003_0002_0001_0000, then 8 consecutive `pix_req`. Expect `pix_data` 0,1,…,7, each one cycle after its request. The next word loads on the 9th request.
- **Underflow:** no `rd_ack` and `pix_req` held high. Expect `pix_data` = 12'h000 (12'hF0F with the macro) and `underflow`=1 on the first edge. Expect no index advance; the flag clears on `frame_start`.
- **Mid-frame restart:** `frame_start` with 3 reads outstanding. Expect the next 3 `rd_data_valid` words discarded, `fifo_level` staying 0 through them, and `rd_addr` restarting at BASE_ADDR.
- **Frame end:** FRAME_WORDS=4. Expect exactly 4 requests with addresses BASE..BASE+3, then `rd_req` staying 0 until `frame_start`.
- **Async reset:** assert `hdmi_rst_n` low between clock edges mid-burst. Expect all outputs at reset values immediately, without waiting for a clock edge.
